// File: rtl/esc_ramp_ctrl.sv
// ESC arming / throttle ramp controller with kill and optional command watchdog.
// Optional failsafe watchdog enabled by defining ESC_FAILSAFE_EN.
module esc_ramp_ctrl #(
  parameter int unsigned FRAME_DIV      = 100000,
  parameter int unsigned ARM_FRAMES     = 50,
  parameter int unsigned STEP           = 4,
  parameter int unsigned TIMEOUT_FRAMES = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arm_req,
  input  logic       kill,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       esc_en,
  output logic [7:0] esc_inp,
  output logic [1:0] state,
  output logic       fault
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMING = 2'd1,
    RUN    = 2'd2,
    DISARM = 2'd3
  } state_t;

  localparam int unsigned FCW   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int unsigned ACW   = (ARM_FRAMES > 0) ? $clog2(ARM_FRAMES + 1) : 1;
  localparam logic [8:0]  STEP9 = 9'(STEP);

  state_t         st;
  logic [FCW-1:0] frame_cnt;
  logic           tick;
  logic [ACW-1:0] arm_cnt;
  logic [7:0]     target;
  logic [7:0]     ramp_next;
  logic [8:0]     diff;
  logic [8:0]     mag;
  logic           accept;

`ifdef ESC_FAILSAFE_EN
  localparam int unsigned WCW = $clog2(TIMEOUT_FRAMES + 1);
  logic [WCW-1:0] wdog;
  logic           fault_q;
  logic           timeout;

  assign fault   = fault_q;
  assign timeout = tick && !accept && (wdog == WCW'(TIMEOUT_FRAMES - 1));
`else
  assign fault = 1'b0;
`endif

  assign tick   = (frame_cnt == FCW'(FRAME_DIV - 1));
  assign accept = cmd_valid && cmd_ready;
  assign state  = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (tick) begin
      frame_cnt <= '0;
    end else begin
      frame_cnt <= frame_cnt + FCW'(1);
    end
  end

  // Signed 9-bit difference: saturate the step at the target so it never overshoots or wraps.
  always_comb begin
    diff      = {1'b0, target} - {1'b0, esc_inp};
    mag       = '0;
    ramp_next = esc_inp;
    if (diff[8]) begin
      mag       = 9'(-diff);
      ramp_next = (mag > STEP9) ? esc_inp - STEP9[7:0] : target;
    end else if (diff != '0) begin
      ramp_next = (diff > STEP9) ? esc_inp + STEP9[7:0] : target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      esc_en    <= 1'b0;
      esc_inp   <= '0;
      cmd_ready <= 1'b0;
      target    <= '0;
      arm_cnt   <= '0;
`ifdef ESC_FAILSAFE_EN
      wdog      <= '0;
      fault_q   <= 1'b0;
`endif
    end else if (kill) begin
      st        <= IDLE;
      esc_en    <= 1'b0;
      esc_inp   <= '0;
      cmd_ready <= 1'b0;
      target    <= '0;
      arm_cnt   <= '0;
`ifdef ESC_FAILSAFE_EN
      wdog      <= '0;
`endif
    end else begin
`ifdef ESC_FAILSAFE_EN
      if (!arm_req) fault_q <= 1'b0;
`endif
      unique case (st)
        IDLE: begin
          esc_en    <= 1'b0;
          esc_inp   <= '0;
          cmd_ready <= 1'b0;
          if (arm_req && !fault) begin
            st      <= ARMING;
            arm_cnt <= '0;
            esc_en  <= 1'b1;
          end
        end
        ARMING: begin
          esc_inp <= '0;
          if (!arm_req) begin
            st     <= IDLE;
            esc_en <= 1'b0;
          end else if (tick) begin
            if (arm_cnt == ACW'(ARM_FRAMES - 1)) begin
              st        <= RUN;
              target    <= '0;
              cmd_ready <= 1'b1;
              arm_cnt   <= '0;
`ifdef ESC_FAILSAFE_EN
              wdog      <= '0;
`endif
            end else begin
              arm_cnt <= arm_cnt + ACW'(1);
            end
          end
        end
        RUN: begin
          // Ramp reads the pre-edge target, so a command accepted on a tick takes effect next frame.
          if (tick) esc_inp <= ramp_next;
          if (accept) target <= cmd_data;
`ifdef ESC_FAILSAFE_EN
          if (accept) begin
            wdog <= '0;
          end else if (tick) begin
            wdog <= wdog + WCW'(1);
          end
`endif
          if (!arm_req) begin
            st        <= DISARM;
            target    <= '0;
            cmd_ready <= 1'b0;
`ifdef ESC_FAILSAFE_EN
          end else if (timeout) begin
            st        <= DISARM;
            target    <= '0;
            cmd_ready <= 1'b0;
            fault_q   <= 1'b1;
            wdog      <= '0;
`endif
          end
        end
        DISARM: begin
          cmd_ready <= 1'b0;
          if (esc_inp == '0) begin
            st     <= IDLE;
            esc_en <= 1'b0;
          end else if (tick) begin
            esc_inp <= ramp_next;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_esc_ramp_ctrl.sv
// Directed bench for esc_ramp_ctrl: vector table for arm/ramp/disarm plus hand sequences.
module tb_esc_ramp_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       arm_req = 1'b0;
  logic       kill = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_data = 8'd0;
  logic       cmd_ready;
  logic       esc_en;
  logic [7:0] esc_inp;
  logic [1:0] state;
  logic       fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  esc_ramp_ctrl #(
    .FRAME_DIV(4),
    .ARM_FRAMES(3),
    .STEP(10),
    .TIMEOUT_FRAMES(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .arm_req(arm_req),
    .kill(kill),
    .cmd_valid(cmd_valid),
    .cmd_data(cmd_data),
    .cmd_ready(cmd_ready),
    .esc_en(esc_en),
    .esc_inp(esc_inp),
    .state(state),
    .fault(fault)
  );

  typedef struct {
    int         ncyc;
    logic       arm;
    logic       vld;
    logic [7:0] data;
    logic [1:0] st;
    logic       en;
    logic [7:0] inp;
    logic       rdy;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input int st, input int en, input int inp,
                            input int rdy, input int flt);
    chk({name, ".state"}, int'(state), st);
    chk({name, ".esc_en"}, int'(esc_en), en);
    chk({name, ".esc_inp"}, int'(esc_inp), inp);
    chk({name, ".cmd_ready"}, int'(cmd_ready), rdy);
    chk({name, ".fault"}, int'(fault), flt);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input string name, input int s);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1);
      if (int'(state) == s) found = 1'b1;
    end
    chk(name, int'(state), s);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected end before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1, 1'b1, 1'b0, 8'd0,  2'd1, 1'b1, 8'd0,  1'b0};
    vecs[1]  = '{2, 1'b1, 1'b0, 8'd0,  2'd1, 1'b1, 8'd0,  1'b0};
    vecs[2]  = '{1, 1'b1, 1'b0, 8'd0,  2'd1, 1'b1, 8'd0,  1'b0};
    vecs[3]  = '{7, 1'b1, 1'b0, 8'd0,  2'd1, 1'b1, 8'd0,  1'b0};
    vecs[4]  = '{1, 1'b1, 1'b0, 8'd0,  2'd2, 1'b1, 8'd0,  1'b1};
    vecs[5]  = '{1, 1'b1, 1'b1, 8'd25, 2'd2, 1'b1, 8'd0,  1'b1};
    vecs[6]  = '{3, 1'b1, 1'b0, 8'd0,  2'd2, 1'b1, 8'd10, 1'b1};
    vecs[7]  = '{3, 1'b1, 1'b0, 8'd0,  2'd2, 1'b1, 8'd10, 1'b1};
    vecs[8]  = '{1, 1'b1, 1'b0, 8'd0,  2'd2, 1'b1, 8'd20, 1'b1};
    vecs[9]  = '{4, 1'b1, 1'b0, 8'd0,  2'd2, 1'b1, 8'd25, 1'b1};
    vecs[10] = '{4, 1'b1, 1'b0, 8'd0,  2'd2, 1'b1, 8'd25, 1'b1};
    vecs[11] = '{1, 1'b0, 1'b0, 8'd0,  2'd3, 1'b1, 8'd25, 1'b0};
    vecs[12] = '{3, 1'b0, 1'b0, 8'd0,  2'd3, 1'b1, 8'd15, 1'b0};
    vecs[13] = '{4, 1'b0, 1'b0, 8'd0,  2'd3, 1'b1, 8'd5,  1'b0};
    vecs[14] = '{4, 1'b0, 1'b0, 8'd0,  2'd3, 1'b1, 8'd0,  1'b0};
    vecs[15] = '{1, 1'b0, 1'b0, 8'd0,  2'd0, 1'b0, 8'd0,  1'b0};

    #12;
    check_outs("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Arm, ramp up to 25, disarm and ramp down; tick edges are 4, 8, 12, ...
    for (int i = 0; i < 16; i++) begin
      arm_req   = vecs[i].arm;
      cmd_valid = vecs[i].vld;
      cmd_data  = vecs[i].data;
      step(vecs[i].ncyc);
      check_outs($sformatf("vec%0d", i), int'(vecs[i].st), int'(vecs[i].en),
                 int'(vecs[i].inp), int'(vecs[i].rdy), 0);
    end
    cmd_valid = 1'b0;

    // RUN is entered on a tick edge, so the next tick is four edges later.
    arm_req = 1'b1;
    wait_state("rearm_run", 2);
    step(3);
    cmd_valid = 1'b1; cmd_data = 8'd50;
    step(1);
    cmd_valid = 1'b0;
    chk("tick_accept_old_target", int'(esc_inp), 0);
    step(4);
    chk("tick_accept_new_target", int'(esc_inp), 10);
    cmd_valid = 1'b1; cmd_data = 8'd3;
    step(1);
    cmd_valid = 1'b0;
    step(3);
    chk("ramp_down_no_overshoot", int'(esc_inp), 3);
    cmd_valid = 1'b1; cmd_data = 8'd20;
    step(1);
    cmd_valid = 1'b0;
    step(3);
    chk("ramp_up_13", int'(esc_inp), 13);
    step(4);
    chk("ramp_up_20", int'(esc_inp), 20);
    kill = 1'b1;
    step(1);
    check_outs("kill", 0, 0, 0, 0, 0);
    kill = 1'b0;

    // Asynchronous reset between edges during a ramp.
    wait_state("run_before_reset", 2);
    cmd_valid = 1'b1; cmd_data = 8'd100;
    step(1);
    cmd_valid = 1'b0;
    step(3);
    chk("ramp_before_reset", int'(esc_inp), 10);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("async_reset", 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b1;

`ifdef ESC_FAILSAFE_EN
    wait_state("fs_run", 2);
    cmd_valid = 1'b1; cmd_data = 8'd30;
    step(1);
    cmd_valid = 1'b0;
    step(3);
    chk("fs_ramp10", int'(esc_inp), 10);
    step(15);
    check_outs("fs_before_timeout", 2, 1, 30, 1, 0);
    step(1);
    check_outs("fs_timeout", 3, 1, 30, 0, 1);
    step(4);
    chk("fs_ramp20", int'(esc_inp), 20);
    step(8);
    check_outs("fs_ramp0", 3, 1, 0, 0, 1);
    step(1);
    check_outs("fs_idle", 0, 0, 0, 0, 1);
    step(8);
    check_outs("fs_no_rearm", 0, 0, 0, 0, 1);
    arm_req = 1'b0;
    step(1);
    check_outs("fs_clear", 0, 0, 0, 0, 0);

    // Command accepted on the timeout tick keeps RUN.
    arm_req = 1'b1;
    wait_state("fs2_run", 2);
    step(19);
    cmd_valid = 1'b1; cmd_data = 8'd0;
    step(1);
    cmd_valid = 1'b0;
    check_outs("accept_wins", 2, 1, 0, 1, 0);
    step(4);
    check_outs("accept_wins_later", 2, 1, 0, 1, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
